// File: rtl/usb_tx_pkg.sv
// Shared types and status codes for the USB TX FIFO read path.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } tx_rd_state_t;

    localparam logic [1:0] TXRD_OK       = 2'b00;
    localparam logic [1:0] TXRD_TIMEOUT  = 2'b01;
    localparam logic [1:0] TXRD_UNDERRUN = 2'b10;
    localparam logic [1:0] TXRD_ABORT    = 2'b11;

endpackage

// File: rtl/usb_tx_fifo_reader.sv
// Drains a packet of byte_count bytes from a first-word fall-through FIFO
// onto a valid/ready transmit handshake, reporting completion status.
module usb_tx_fifo_reader
    import usb_tx_pkg::*;
#(
    parameter int unsigned DSIZE   = 8,
    parameter int unsigned LSIZE   = 11,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LSIZE-1:0] byte_count,
    input  logic             abort,
    input  logic [DSIZE-1:0] fifo_read_data,
    input  logic             fifo_empty,
    output logic             fifo_read_enable,
    output logic             fifo_clear,
    output logic [DSIZE-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);

    localparam int unsigned     TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    tx_rd_state_t     state, state_nxt;
    logic [LSIZE-1:0] remaining, remaining_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic [DSIZE-1:0] tx_data_nxt;
    logic             tx_valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [1:0]       err_nxt;
    logic             fifo_clear_nxt;

    // State and output registers; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            tcnt       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= TXRD_OK;
            fifo_clear <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            tcnt       <= tcnt_nxt;
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            fifo_clear <= fifo_clear_nxt;
        end
    end

    // Next-state logic; done is raised on entry to FINISH so it coincides
    // with the FINISH cycle, and abort overrides every other event.
    always_comb begin
        state_nxt        = state;
        remaining_nxt    = remaining;
        tcnt_nxt         = tcnt;
        tx_data_nxt      = tx_data;
        tx_valid_nxt     = tx_valid;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        err_nxt          = err;
        fifo_clear_nxt   = 1'b0;
        fifo_read_enable = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    err_nxt = TXRD_OK;
                    if (byte_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        remaining_nxt = byte_count;
                        tcnt_nxt      = '0;
                        busy_nxt      = 1'b1;
                        state_nxt     = FETCH;
                    end
                end
            end

            FETCH: begin
                if (abort) begin
                    tx_valid_nxt   = 1'b0;
                    fifo_clear_nxt = 1'b1;
                    err_nxt        = TXRD_ABORT;
                    done_nxt       = 1'b1;
                    state_nxt      = FINISH;
                end else if (!fifo_empty) begin
                    fifo_read_enable = 1'b1;
                    tx_data_nxt      = fifo_read_data;
                    tx_valid_nxt     = 1'b1;
                    remaining_nxt    = remaining - 1'b1;
                    state_nxt        = SEND;
                end else if (tcnt == TLAST) begin
                    fifo_clear_nxt = 1'b1;
                    err_nxt        = TXRD_TIMEOUT;
                    done_nxt       = 1'b1;
                    state_nxt      = FINISH;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end

            SEND: begin
                if (abort) begin
                    tx_valid_nxt   = 1'b0;
                    fifo_clear_nxt = 1'b1;
                    err_nxt        = TXRD_ABORT;
                    done_nxt       = 1'b1;
                    state_nxt      = FINISH;
                end else if (tx_ready) begin
                    if (remaining == '0) begin
                        tx_valid_nxt = 1'b0;
                        err_nxt      = TXRD_OK;
                        done_nxt     = 1'b1;
                        state_nxt    = FINISH;
                    end else if (!fifo_empty) begin
                        fifo_read_enable = 1'b1;
                        tx_data_nxt      = fifo_read_data;
                        remaining_nxt    = remaining - 1'b1;
                    end else begin
                        tx_valid_nxt   = 1'b0;
                        fifo_clear_nxt = 1'b1;
                        err_nxt        = TXRD_UNDERRUN;
                        done_nxt       = 1'b1;
                        state_nxt      = FINISH;
                    end
                end
            end

            FINISH: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_fifo_reader.sv
// Directed bench for usb_tx_fifo_reader with a small FWFT FIFO model.
module tb_usb_tx_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] byte_count = '0;
    logic        abort = 1'b0;
    logic [7:0]  fifo_read_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read_enable;
    logic        fifo_clear;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    // bench-side FIFO write port and flush
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        flush_req = 1'b0;

    int checks = 0;
    int failures = 0;

    usb_tx_fifo_reader #(.DSIZE(8), .LSIZE(11), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .byte_count       (byte_count),
        .abort            (abort),
        .fifo_read_data   (fifo_read_data),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_clear       (fifo_clear),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: pop, flush and write take effect at the clock edge
    logic [7:0] fq[$];
    always @(posedge clk) begin
        if (flush_req) begin
            fq.delete();
        end else begin
            if (fifo_read_enable && fq.size() > 0) void'(fq.pop_front());
            if (fifo_clear) fq.delete();
            if (wr_en) fq.push_back(wr_data);
        end
        fifo_empty     <= (fq.size() == 0);
        fifo_read_data <= (fq.size() > 0) ? fq[0] : 8'h00;
    end

    // monitor: cumulative event counters and the accepted-byte log
    logic [7:0] sent[$];
    int n_pop = 0, n_clear = 0, n_done = 0, n_valid = 0, bad_pop = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) sent.push_back(tx_data);
            if (tx_valid) n_valid++;
            if (fifo_read_enable) n_pop++;
            if (fifo_read_enable && fifo_empty) bad_pop++;
            if (fifo_clear) n_clear++;
            if (done) n_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int b_sent, b_pop, b_clear, b_done, b_valid;
    task automatic snap();
        b_sent  = sent.size();
        b_pop   = n_pop;
        b_clear = n_clear;
        b_done  = n_done;
        b_valid = n_valid;
    endtask

    task automatic prefill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
    endtask

    // issues a start at the current negedge and counts negedges until done
    task automatic run_pkt(input logic [10:0] cnt, input bit toggle_rdy,
                           input int abort_at, input int budget, output int cyc);
        bit found = 0;
        start      = 1'b1;
        byte_count = cnt;
        cyc        = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (toggle_rdy) tx_ready = ~tx_ready;
            if (cyc == abort_at) begin
                abort = 1'b1;
                #1;
                check("abort_no_pop", {31'b0, fifo_read_enable}, 32'd0);
                check("abort_valid", {31'b0, tx_valid}, 32'd1);
            end
            if (done) begin
                found = 1;
                break;
            end
        end
        abort    = 1'b0;
        tx_ready = 1'b1;
        if (!found) begin
            check("done_wait", 32'd0, 32'd1);
            cyc = -1;
        end
    endtask

    int cyc;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {30'b0, err}, 32'd0);
        check("rst_clear", {31'b0, fifo_clear}, 32'd0);
        check("rst_rden", {31'b0, fifo_read_enable}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four bytes, PHY always ready
        prefill(8'hA0, 4);
        snap();
        run_pkt(11'd4, 0, -1, 100, cyc);
        check("t1_lat", cyc, 32'd6);
        check("t1_err", {30'b0, err}, 32'd0);
        check("t1_nsent", sent.size() - b_sent, 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_byte%0d", i), {24'b0, sent[b_sent + i]}, 32'hA0 + i);
        check("t1_valid_cyc", n_valid - b_valid, 32'd4);
        check("t1_clear", n_clear - b_clear, 32'd0);
        @(negedge clk);
        check("t1_busy_after", {31'b0, busy}, 32'd0);
        check("t1_done_pulse", {31'b0, done}, 32'd0);
        check("t1_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // 2: PHY ready alternates, bytes held while not ready
        prefill(8'hB0, 4);
        snap();
        run_pkt(11'd4, 1, -1, 100, cyc);
        check("t2_lat", cyc, 32'd9);
        check("t2_err", {30'b0, err}, 32'd0);
        check("t2_nsent", sent.size() - b_sent, 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_byte%0d", i), {24'b0, sent[b_sent + i]}, 32'hB0 + i);
        check("t2_valid_cyc", n_valid - b_valid, 32'd7);
        check("t2_pops", n_pop - b_pop, 32'd4);
        @(negedge clk);

        // 3: first-byte timeout on an empty FIFO
        snap();
        run_pkt(11'd3, 0, -1, 100, cyc);
        check("t3_lat", cyc, 32'd17);
        check("t3_err", {30'b0, err}, 32'd1);
        check("t3_clear_now", {31'b0, fifo_clear}, 32'd1);
        check("t3_valid_cyc", n_valid - b_valid, 32'd0);
        check("t3_pops", n_pop - b_pop, 32'd0);
        @(negedge clk);
        check("t3_clear_once", n_clear - b_clear, 32'd1);

        // 4: underrun after two of five bytes
        prefill(8'hC0, 2);
        snap();
        run_pkt(11'd5, 0, -1, 100, cyc);
        check("t4_lat", cyc, 32'd4);
        check("t4_err", {30'b0, err}, 32'd2);
        check("t4_clear_now", {31'b0, fifo_clear}, 32'd1);
        check("t4_valid_now", {31'b0, tx_valid}, 32'd0);
        check("t4_nsent", sent.size() - b_sent, 32'd2);
        check("t4_byte0", {24'b0, sent[b_sent]}, 32'hC0);
        check("t4_byte1", {24'b0, sent[b_sent + 1]}, 32'hC1);
        @(negedge clk);

        // 5: abort during the third byte handshake of ten
        prefill(8'hD0, 10);
        snap();
        run_pkt(11'd10, 0, 4, 100, cyc);
        check("t5_lat", cyc, 32'd5);
        check("t5_err", {30'b0, err}, 32'd3);
        check("t5_valid_now", {31'b0, tx_valid}, 32'd0);
        check("t5_clear_now", {31'b0, fifo_clear}, 32'd1);
        check("t5_pops", n_pop - b_pop, 32'd3);
        check("t5_byte2", {24'b0, sent[b_sent + 2]}, 32'hD2);
        @(negedge clk);
        check("t5_fifo_flushed", {31'b0, fifo_empty}, 32'd1);

        // 6: zero-length packet
        snap();
        run_pkt(11'd0, 0, -1, 10, cyc);
        check("t6_lat", cyc, 32'd1);
        check("t6_err", {30'b0, err}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("t6_pops", n_pop - b_pop, 32'd0);
        check("t6_valid_cyc", n_valid - b_valid, 32'd0);

        // reset in the middle of a packet
        do_flush();
        prefill(8'hE0, 3);
        snap();
        start      = 1'b1;
        byte_count = 11'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_valid", {31'b0, tx_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_valid", {31'b0, tx_valid}, 32'd0);
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_data", {24'b0, tx_data}, 32'd0);
        check("mid_rden", {31'b0, fifo_read_enable}, 32'd0);
        check("mid_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_done", n_done - b_done, 32'd0);
        check("mid_idle_valid", {31'b0, tx_valid}, 32'd0);

        check("no_pop_when_empty", bad_pop, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
